// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch and data ports.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on ties instead of fixed data-first priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              stall_if,
  output logic              stall_d,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Resets to D so that the very first tie goes to the fetch port.
  logic last_grant_q, last_grant_d;

  always_comb begin
    if (if_req && d_req) begin
      grant_d = (last_grant_q == OWN_I);
    end else begin
      grant_d = d_req;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && (if_req || d_req)) begin
      last_grant_d = grant_d ? OWN_D : OWN_I;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= OWN_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Data port always wins a tie; the fetch port can starve.
  always_comb begin
    grant_d = d_req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          owner_d     = grant_d ? OWN_D : OWN_I;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_d & d_we;
          mem_addr_d  = grant_d ? d_addr : if_addr;
          mem_wdata_d = grant_d ? d_wdata : '0;
          cnt_d       = CNT_LOAD;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        if (cnt_q == '0) begin
          // mem_we_q still tells a store apart from a load in this last cycle.
          if (owner_q == OWN_I) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
            d_ready_d = 1'b1;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;

  // Stalls must follow the request combinationally so the PC freezes in the request cycle.
  assign stall_if = if_req & ~if_ready_q;
  assign stall_d  = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word-addressed memory model (MEM_LAT=2).
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        stall_if;
  logic        stall_d;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem_model [0:63];
  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall_if(stall_if), .stall_d(stall_d),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_model[mem_addr[7:2]];

  initial begin
    for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
    mem_model[16] = 32'h2008_0005;
    mem_model[8]  = 32'h1234_5678;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) mem_model[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n_if_rdy;
  int n_d_rdy;

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    step(); step();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_ready", {if_ready, d_ready}, 0);
    reset = 1'b1;
    step();

    // Fetch only
    if_addr = 32'h40; if_req = 1'b1;
    #1 check("f_stall_req_cycle", stall_if, 1);
    check("f_stall_d", stall_d, 0);
    step();
    check("f_b1_en", mem_en, 1);
    check("f_b1_we", mem_we, 0);
    check("f_b1_addr", mem_addr, 32'h40);
    check("f_b1_stall", stall_if, 1);
    step();
    check("f_b2_en", mem_en, 1);
    check("f_b2_ready", if_ready, 0);
    check("f_b2_stall", stall_if, 1);
    step();
    check("f_resp_ready", if_ready, 1);
    check("f_resp_rdata", if_rdata, 32'h2008_0005);
    check("f_resp_en", mem_en, 0);
    check("f_resp_stall", stall_if, 0);
    if_req = 1'b0;
    step();
    check("f_idle_ready", if_ready, 0);
    check("f_idle_rdata_hold", if_rdata, 32'h2008_0005);

    // Store 0xDEADBEEF to 0x10
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    step();
    check("st_b1_we", mem_we, 1);
    check("st_b1_addr", mem_addr, 32'h10);
    check("st_b1_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    check("st_b2_we", mem_we, 1);
    step();
    check("st_resp_ready", d_ready, 1);
    check("st_resp_we", mem_we, 0);
    check("st_resp_rdata_unchanged", d_rdata, 0);
    d_req = 1'b0; d_we = 1'b0;
    step();

    // Load 0x10, with d_addr changed during BUSY
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    step();
    check("ld_b1_we", mem_we, 0);
    check("ld_b1_addr", mem_addr, 32'h10);
    d_addr = 32'h20;
    step();
    check("ld_b2_addr_hold", mem_addr, 32'h10);
    step();
    check("ld_resp_ready", d_ready, 1);
    check("ld_resp_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    step();

    // Tie: both requests rise together
    if_addr = 32'h40; d_addr = 32'h20; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    step();
    check("tie_first_addr", mem_addr, RR ? 32'h40 : 32'h20);
    step();
    check("tie_loser_stall", RR ? stall_d : stall_if, 1);
    step();
    check("tie_first_if_ready", if_ready, RR ? 1 : 0);
    check("tie_first_d_ready", d_ready, RR ? 0 : 1);
    if (RR) if_req = 1'b0; else d_req = 1'b0;
    step();
    check("tie_gap_ready", {if_ready, d_ready}, 0);
    step();
    check("tie_second_addr", mem_addr, RR ? 32'h20 : 32'h40);
    step();
    step();
    check("tie_second_if_ready", if_ready, RR ? 0 : 1);
    check("tie_second_d_ready", d_ready, RR ? 1 : 0);
    check("tie_if_rdata", if_rdata, 32'h2008_0005);
    check("tie_d_rdata", d_rdata, 32'h1234_5678);
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Continuous requests on both ports for 8 accesses
    n_if_rdy = 0; n_d_rdy = 0;
    if_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 32; c++) begin
      step();
      if (if_ready) n_if_rdy++;
      if (d_ready) n_d_rdy++;
      if (n_if_rdy + n_d_rdy == 8) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    check("cont_fetches", n_if_rdy, RR ? 4 : 0);
    check("cont_data", n_d_rdy, RR ? 4 : 8);
    step();

    // Reset during the first BUSY cycle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFE_F00D;
    step();
    check("ra_b1_we", mem_we, 1);
    #2 reset = 1'b0;
    #1 check("ra_en_cleared", mem_en, 0);
    check("ra_we_cleared", mem_we, 0);
    check("ra_stall_d", stall_d, 1);
    step();
    check("ra_no_ready", d_ready, 0);
    reset = 1'b1;
    step();
    check("ra_reissue_en", mem_en, 1);
    check("ra_reissue_we", mem_we, 1);
    check("ra_reissue_addr", mem_addr, 32'h30);
    step();
    step();
    check("ra_reissue_ready", d_ready, 1);
    d_req = 1'b0; d_we = 1'b0;
    step();
    d_req = 1'b1; d_addr = 32'h30;
    step(); step(); step();
    check("ra_load_ready", d_ready, 1);
    check("ra_load_rdata", d_rdata, 32'hCAFE_F00D);
    d_req = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
